// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M execution unit: a radix-2 shift-add multiplier and a
// restoring divider share one double-width accumulator. One result is
// returned per accepted operation; busy_o stalls EX while iterating.
module muldiv_iter_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q,  state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   opnd_q,   opnd_d;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q,    acc_d;     // {hi, lo}: product, or {remainder, quotient}
  logic              sign_x_q, sign_x_d;  // operand signs differ (product / quotient)
  logic              sign_a_q, sign_a_d;  // dividend negative (remainder)
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] step_acc, prod_fix;
  logic [XLEN-1:0]   final_res;

  // Operand decode at the accept edge: signedness, magnitudes, special cases.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see
    // the values computed earlier in the same evaluation.
    accept   = (state_q == S_IDLE || state_q == S_DONE) && start_i && !flush_i;
    a_neg    = (funct3_i == 3'b001 || funct3_i == 3'b010 ||
                funct3_i == 3'b100 || funct3_i == 3'b110) && op_a_i[XLEN-1];
    b_neg    = (funct3_i == 3'b001 || funct3_i == 3'b100 ||
                funct3_i == 3'b110) && op_b_i[XLEN-1];
    a_mag    = a_neg ? -op_a_i : op_a_i;
    b_mag    = b_neg ? -op_b_i : op_b_i;
    div_zero = funct3_i[2] && (op_b_i == '0);
    div_ovf  = (funct3_i == 3'b100 || funct3_i == 3'b110) &&
               (op_a_i == MIN_NEG) && (op_b_i == '1);
    if (funct3_i[1]) special_res = div_zero ? op_a_i : '0;
    else             special_res = div_zero ? '1 : MIN_NEG;
  end

  // One iteration step: shift-add for multiply, shift/trial-subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (!funct3_q[2]) begin
      step_acc = {mul_sum, acc_q[XLEN-1:1]};
    end else if (div_trial[XLEN]) begin
      // Trial went negative: keep the shifted remainder, quotient bit 0.
      step_acc = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      step_acc = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Sign fixup and result selection from the last iteration's accumulator.
  always_comb begin
    prod_fix = sign_x_q ? -step_acc : step_acc;
    case (funct3_q)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = sign_x_q ? -step_acc[XLEN-1:0]
                                                   : step_acc[XLEN-1:0];
      default:                final_res = sign_a_q ? -step_acc[2*XLEN-1:XLEN]
                                                   : step_acc[2*XLEN-1:XLEN];
    endcase
  end

  // Next-state logic for the IDLE/CALC/DONE sequencer and datapath registers.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    funct3_d = funct3_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    sign_x_d = sign_x_q;
    sign_a_d = sign_a_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          funct3_d = funct3_i;
          sign_x_d = a_neg ^ b_neg;
          sign_a_d = a_neg;
          opnd_d   = funct3_i[2] ? b_mag : a_mag;
          acc_d    = {{XLEN{1'b0}}, (funct3_i[2] ? a_mag : b_mag)};
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d = final_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A flush abandons the operation without touching the visible result.
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      sign_x_q <= 1'b0;
      sign_a_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      sign_x_q <= sign_x_d;
      sign_a_q <= sign_a_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == S_CALC);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Bench for muldiv_iter_unit: a 32-bit and a 16-bit instance are checked
// cycle by cycle against an arithmetic reference model.
module tb_muldiv_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        s32, fl32;
  logic [2:0]  fn32;
  logic [31:0] a32, b32, r32;
  logic        busy32, valid32;
  logic        s16, fl16;
  logic [2:0]  fn16;
  logic [15:0] a16, b16, r16;
  logic        busy16, valid16;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] last32      = '0;
  logic [31:0] last16      = '0;

  always #5 clk = ~clk;

  muldiv_iter_unit #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(s32), .funct3_i(fn32), .op_a_i(a32),
    .op_b_i(b32), .flush_i(fl32), .busy_o(busy32), .valid_o(valid32),
    .result_o(r32)
  );

  muldiv_iter_unit #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .start_i(s16), .funct3_i(fn16), .op_a_i(a16),
    .op_b_i(b16), .flush_i(fl16), .busy_o(busy16), .valid_o(valid16),
    .result_o(r16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input int w, input logic [2:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
    longint mask = (longint'(1) << w) - 1;
    longint sa   = longint'(a) & mask;
    longint sb   = longint'(b) & mask;
    longint p;
    bit     a_s  = (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
    bit     b_s  = (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
    if (a_s && a[w-1]) sa = sa - (longint'(1) << w);
    if (b_s && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    case (f)
      3'd0:             return 32'(p & mask);
      3'd1, 3'd2, 3'd3: return 32'((p >>> w) & mask);
      3'd4, 3'd5:       return (sb == 0) ? 32'(mask) : 32'((sa / sb) & mask);
      default:          return (sb == 0) ? 32'(longint'(a) & mask) : 32'((sa % sb) & mask);
    endcase
  endfunction

  function automatic bit is_special(input int w, input logic [2:0] f,
                                    input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m    = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    logic [31:0] minv = 32'h1 << (w - 1);
    return (f[2] && (b & m) == 0) ||
           ((f == 3'd4 || f == 3'd6) && (a & m) == minv && (b & m) == m);
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return m;
      3:       return 32'h1 << (w - 1);
      default: return $urandom & m;
    endcase
  endfunction

  task automatic drive(input bit w16, input logic st, input logic fl, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    if (w16) begin
      s16 = st; fl16 = fl; fn16 = f; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      s32 = st; fl32 = fl; fn32 = f; a32 = a; b32 = b;
    end
  endtask

  // Issue one op, then check busy/valid/result every cycle. Optional
  // disturbances: a start pulse, a flush or a reset during a given cycle.
  task automatic run_op(input bit w16, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input string tag, input int pulse_c = -1,
                        input int flush_c = -1, input int rst_c = -1);
    int          w       = w16 ? 16 : 32;
    logic [31:0] exp     = ref_model(w, f, a, b);
    bit          sp      = is_special(w, f, a, b);
    int          vc      = sp ? 1 : w + 1;
    bit          done_ok = (flush_c < 0) && (rst_c < 0);
    logic [31:0] prior   = w16 ? last16 : last32;
    logic        eb, ev;
    logic [31:0] er;
    drive(w16, 1'b1, 1'b0, f, a, b);
    @(posedge clk);
    #1;
    drive(w16, 1'b0, 1'b0, 3'($urandom), $urandom, $urandom);
    for (int c = 1; c <= w + 3; c++) begin
      @(negedge clk);
      eb = !sp && c <= w && (flush_c < 0 || c <= flush_c) && (rst_c < 0 || c <= rst_c);
      ev = done_ok && c == vc;
      if (rst_c >= 0 && c > rst_c) er = '0;
      else if (done_ok && c >= vc) er = exp;
      else                         er = prior;
      chk($sformatf("%s busy c%0d", tag, c), 32'(w16 ? busy16 : busy32), 32'(eb));
      chk($sformatf("%s valid c%0d", tag, c), 32'(w16 ? valid16 : valid32), 32'(ev));
      chk($sformatf("%s result c%0d", tag, c), w16 ? {16'h0, r16} : r32, er);
      rst = (c == rst_c);
      drive(w16, c == pulse_c, c == flush_c, 3'($urandom), $urandom, $urandom);
    end
    rst = 1'b0;
    drive(w16, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    if (rst_c >= 0) begin
      last32 = '0;
      last16 = '0;
    end else if (done_ok) begin
      if (w16) last16 = exp;
      else     last32 = exp;
    end
  endtask

  initial begin
    int vcyc;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy32", 32'(busy32), 32'h0);
    chk("reset valid32", 32'(valid32), 32'h0);
    chk("reset result32", r32, 32'h0);
    chk("reset busy16", 32'(busy16), 32'h0);
    chk("reset valid16", 32'(valid16), 32'h0);
    chk("reset result16", {16'h0, r16}, 32'h0);
    rst = 1'b0;

    // Directed arithmetic, 32-bit.
    run_op(1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, "mul 7xfffffffd");
    run_op(1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, "mulh min*min");
    run_op(1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu ones");
    run_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'd2, "mulhsu -1x2");
    run_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    run_op(1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, "rem -7/2");
    run_op(1'b0, 3'b101, 32'd100, 32'd7, "divu 100/7");
    run_op(1'b0, 3'b111, 32'd100, 32'd7, "remu 100/7");

    // Special cases bypass CALC.
    run_op(1'b0, 3'b100, 32'd5, 32'd0, "div 5/0");
    run_op(1'b0, 3'b111, 32'd5, 32'd0, "remu 5/0");
    run_op(1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    run_op(1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");

    // Control interactions.
    run_op(1'b0, 3'b000, 32'h0001_2345, 32'h0000_9876, "mul start-pulse", 5);
    run_op(1'b0, 3'b101, 32'h00FF_0000, 32'd3, "divu flush", -1, 10);

    drive(1'b0, 1'b1, 1'b1, 3'b000, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("flush+start busy c%0d", c), 32'(busy32), 32'h0);
      chk($sformatf("flush+start valid c%0d", c), 32'(valid32), 32'h0);
      chk($sformatf("flush+start result c%0d", c), r32, last32);
    end

    // Back-to-back issue from the DONE cycle.
    drive(1'b0, 1'b1, 1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    vcyc = -1;
    for (int c = 1; c <= 40 && vcyc < 0; c++) begin
      @(negedge clk);
      if (valid32) vcyc = c;
    end
    chk("b2b first valid cycle", 32'(vcyc), 32'd33);
    chk("b2b first result", r32, 32'hFFFF_FFEB);
    drive(1'b0, 1'b1, 1'b0, 3'b101, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    vcyc = -1;
    for (int c = 1; c <= 40 && vcyc < 0; c++) begin
      @(negedge clk);
      if (valid32) vcyc = c;
    end
    chk("b2b second valid cycle", 32'(vcyc), 32'd33);
    chk("b2b second result", r32, 32'd14);
    last32 = 32'd14;
    repeat (2) @(negedge clk);

    // Reset in the middle of a divide.
    run_op(1'b0, 3'b101, 32'd100, 32'd7, "divu rst", -1, -1, 12);

    // Randomized ops against the model, 32-bit.
    for (int i = 0; i < 40; i++)
      run_op(1'b0, 3'($urandom), pick(32), pick(32), $sformatf("rand32 #%0d", i));

    // 16-bit instance.
    run_op(1'b1, 3'b000, 32'd7, 32'h0000_FFFD, "mul16 7xfffd");
    run_op(1'b1, 3'b100, 32'd5, 32'd0, "div16 5/0");
    run_op(1'b1, 3'b110, 32'h0000_8000, 32'h0000_FFFF, "rem16 ovf");
    for (int i = 0; i < 20; i++)
      run_op(1'b1, 3'($urandom), pick(16), pick(16), $sformatf("rand16 #%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
